pm_prefetch_unit: RTL
=====================

Name: pm_prefetch_unit

Overview:
Parametrised program-memory fetch front end for the lab microprocessor, placed between the PC/IR datapath and a slow program ROM with a fixed multi-cycle read latency. It issues sequential ROM reads autonomously and buffers returned words, with their addresses, in a small FIFO. The CPU side consumes instructions through a valid/ready handshake and redirects the fetch stream on jumps. It replaces the hard-wired single-outstanding-read stall path.

Parameters:
AW, 8, program address width (pm_address / pc width)
DW, 8, instruction word width
ROM_LATENCY, 2, cycles rom_addr must be held stable before rom_data is valid; must be >= 1
FIFO_DEPTH, 4, prefetch entries; power of two, >= 2
RESET_ADDR, 0, first fetch address after reset

Ports:
clk  in  1  clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
redirect  in  1  jump/branch: flush and restart fetch at redirect_addr
redirect_addr  in  AW  new fetch address
instr_ready  in  1  CPU consumes the head instruction this cycle
instr_valid  out  1  head instruction available
instr_data  out  DW  head instruction word (to IR)
instr_addr  out  AW  address of the head instruction (to PC)
rom_addr  out  AW  ROM address, registered
rom_rd  out  1  high while a ROM read is in progress
rom_data  in  DW  ROM output, sampled at the end of the last latency cycle

Behaviour:
- Reset values: instr_valid=0, instr_data=0, instr_addr=0, rom_rd=0, rom_addr=RESET_ADDR, FIFO empty, fetch_ptr=RESET_ADDR, lat_cnt=0, state=FETCH.
- FSM has two states.
- FETCH: rom_rd=1 and rom_addr=fetch_ptr, held stable. lat_cnt counts 0..ROM_LATENCY-1. In the cycle with lat_cnt==ROM_LATENCY-1:
  - {fetch_ptr, rom_data} is pushed into the FIFO.
  - fetch_ptr increments modulo 2^AW (0xFF wraps to 0x00 when AW=8).
  - lat_cnt clears.
  - If the FIFO will be full after this push (net of a same-cycle pop), the FSM goes to FULL; otherwise it stays in FETCH.
- FULL: rom_rd=0 and rom_addr holds fetch_ptr. The FSM returns to FETCH in the cycle after any pop, with lat_cnt=0.
- Throughput: one word every ROM_LATENCY cycles while not full. First instr_valid is high ROM_LATENCY cycles after the first cycle with reset low.
- Handshake: a pop occurs when instr_valid && instr_ready. instr_data and instr_addr are the FIFO head, valid whenever the FIFO is non-empty. instr_ready with instr_valid=0 is ignored.
- Simultaneous push and pop: allowed, including when the FIFO is full; the occupancy count stays unchanged.
- Redirect (highest priority over push and pop):
  - FIFO flushed; instr_valid is 0 in the next cycle.
  - Any in-progress read is abandoned and its data discarded.
  - fetch_ptr=redirect_addr, lat_cnt=0, state=FETCH, so rom_addr=redirect_addr in the next cycle.
  - A same-cycle instr_ready pop is dropped.
  - First redirected word is valid ROM_LATENCY+1 cycles after the redirect cycle.
- Reset mid-operation: all state returns to reset values at the next edge, regardless of FSM state or in-flight reads.
- Occupancy counter is $clog2(FIFO_DEPTH)+1 bits wide; pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.

Optional Feature:
Macro FETCH_PERF_EN.
- When defined, adds outputs stall_cycles[15:0] and redirect_count[15:0].
  - stall_cycles increments on every cycle with instr_ready=1 && instr_valid=0.
  - redirect_count increments on every redirect.
  - Both saturate at 16'hFFFF and clear on reset.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package pm_fetch_pkg holds:
  - state enum (FETCH, FULL)
  - default AW/DW localparams
  - helper function for the FIFO pointer width
- Sub-module pm_fetch_fifo: synchronous FIFO of {AW+DW} entries with push, pop, flush, full, empty and count outputs. Flush has priority over push/pop. The top level holds the FSM, latency counter and fetch pointer.

Test Plan:
- Defaults throughout; ROM model returns addr^8'hA5 when rom_addr has been stable ROM_LATENCY cycles.
- Reset release with instr_ready=1 -> instr_valid first in cycle 2; addresses 0x00, 0x01, 0x02… one every 2 cycles; data 0xA5, 0xA4, 0xA7.
- instr_ready=0 from reset -> 4 entries fill, state FULL, rom_rd=0, rom_addr=0x04. Then instr_ready=1 -> 0x00..0x03 pop back-to-back, and rom_rd reasserts the cycle after the first pop.
- Redirect to 0x40 during the second latency cycle of a read -> next cycle instr_valid=0 and rom_addr=0x40; first valid instr_addr=0x40, data 0xE5, three cycles after the redirect.
- Redirect to 0xFE with instr_ready=1 -> instr_addr sequence 0xFE, 0xFF, 0x00, 0x01 with correct data; no gap at the wrap.
- Reset pulsed for one cycle while the FIFO holds 3 entries and a read is in flight -> all outputs at reset values next cycle; restart at 0x00. With FETCH_PERF_EN: 10 starved-ready cycles plus 2 redirects -> stall_cycles=10, redirect_count=2.

Source files
------------

// File: rtl/pm_fetch_pkg.sv
// pm_fetch_pkg
// Shared definitions for the program-memory prefetch front end:
//   - fetch_state_t : FSM state encoding (FETCH, FULL)
//   - PM_AW_DEFAULT / PM_DW_DEFAULT : default address / instruction widths
//   - ptr_width()   : index width for a power-of-two depth (minimum 1 bit)
package pm_fetch_pkg;

  localparam int PM_AW_DEFAULT = 8;
  localparam int PM_DW_DEFAULT = 8;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    FULL  = 1'b1
  } fetch_state_t;

  // Width of an index into a structure of 'depth' entries. Never returns 0,
  // so a depth (or latency) of 1 still gets a legal one-bit counter.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pm_prefetch_unit_if.sv
// pm_prefetch_unit_if
// Bundles the CPU-side fetch handshake and the program ROM bus.
//   CPU side : redirect, redirect_addr, instr_ready  (CPU -> unit)
//              instr_valid, instr_data, instr_addr   (unit -> CPU)
//   ROM side : rom_addr, rom_rd                       (unit -> ROM)
//              rom_data                               (ROM -> unit)
// Modports:
//   slave  - the prefetch unit
//   master - the environment (CPU datapath plus ROM)
interface pm_prefetch_unit_if
  import pm_fetch_pkg::*;
#(
  parameter int AW = PM_AW_DEFAULT,
  parameter int DW = PM_DW_DEFAULT
);

  logic          redirect;
  logic [AW-1:0] redirect_addr;
  logic          instr_ready;
  logic          instr_valid;
  logic [DW-1:0] instr_data;
  logic [AW-1:0] instr_addr;
  logic [AW-1:0] rom_addr;
  logic          rom_rd;
  logic [DW-1:0] rom_data;

  modport slave (
    input  redirect, redirect_addr, instr_ready, rom_data,
    output instr_valid, instr_data, instr_addr, rom_addr, rom_rd
  );

  modport master (
    output redirect, redirect_addr, instr_ready, rom_data,
    input  instr_valid, instr_data, instr_addr, rom_addr, rom_rd
  );

endinterface

// File: rtl/pm_fetch_fifo.sv
// pm_fetch_fifo
// Small synchronous first-word-fall-through FIFO holding {address, word}
// pairs for the prefetch unit.
// Ports:
//   clk, srst       : clock, synchronous active-high reset
//   flush           : empties the FIFO; wins over push and pop
//   push, wdata     : write one entry (accepted when full only if a pop
//                     happens in the same cycle)
//   pop             : drop the head entry (ignored when empty)
//   rdata           : head entry, meaningful only while !empty
//   full, empty     : occupancy flags
//   count           : occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module pm_fetch_fifo
  import pm_fetch_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int PW    = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [PW:0]      count
);

  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  // Only a handful of entries: a register array with a combinational head
  // read keeps the head visible in the same cycle it becomes valid.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == FULL_COUNT);
  assign count   = count_reg;
  assign rdata   = mem[rd_ptr_reg];
  assign do_pop  = pop && !empty;
  // When full, a same-cycle pop frees the slot the push lands in.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (srst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (PW+1)'(1);
        2'b01:   count_reg <= count_reg - (PW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/pm_prefetch_unit.sv
// pm_prefetch_unit
// Program-memory fetch front end. Issues sequential reads to a fixed-latency
// ROM, buffers {address, word} pairs in a FIFO and hands them to the CPU
// through a valid/ready handshake. A redirect flushes everything and
// restarts fetching at redirect_addr.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous active-high reset
//   bus    : pm_prefetch_unit_if.slave (CPU handshake + ROM bus)
//   stall_cycles, redirect_count : 16-bit saturating performance counters,
//            present only when FETCH_PERF_EN is defined
// Optional feature macro: FETCH_PERF_EN
module pm_prefetch_unit
  import pm_fetch_pkg::*;
#(
  parameter int            AW          = PM_AW_DEFAULT,
  parameter int            DW          = PM_DW_DEFAULT,
  parameter int            ROM_LATENCY = 2,
  parameter int            FIFO_DEPTH  = 4,
  parameter logic [AW-1:0] RESET_ADDR  = '0
) (
  input  logic        clk,
  input  logic        reset,
  pm_prefetch_unit_if.slave bus
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] stall_cycles,
  output logic [15:0] redirect_count
`endif
);

  localparam int            LW       = ptr_width(ROM_LATENCY);
  localparam int            CW       = ptr_width(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(ROM_LATENCY - 1);

  fetch_state_t     state_reg, state_next;
  logic [LW-1:0]    lat_cnt_reg, lat_cnt_next;
  logic [AW-1:0]    fetch_ptr_reg, fetch_ptr_next;
  logic             rom_rd_reg, rom_rd_next;

  logic             push, pop, will_be_full;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [AW+DW-1:0] fifo_rdata;

  pm_fetch_fifo #(
    .WIDTH (AW + DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .srst  (reset),
    .flush (bus.redirect),
    .push  (push),
    .pop   (pop),
    .wdata ({fetch_ptr_reg, bus.rom_data}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Occupancy after this cycle's push, net of a same-cycle pop.
  assign will_be_full = (fifo_count + CW'(1) - CW'(pop)) == CW'(FIFO_DEPTH);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= FETCH;
      lat_cnt_reg   <= '0;
      fetch_ptr_reg <= RESET_ADDR;
      rom_rd_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      lat_cnt_reg   <= lat_cnt_next;
      fetch_ptr_reg <= fetch_ptr_next;
      rom_rd_reg    <= rom_rd_next;
    end
  end

  // Next-state logic; redirect overrides everything and abandons the read.
  always_comb begin
    state_next     = state_reg;
    lat_cnt_next   = lat_cnt_reg;
    fetch_ptr_next = fetch_ptr_reg;
    if (bus.redirect) begin
      state_next     = FETCH;
      lat_cnt_next   = '0;
      fetch_ptr_next = bus.redirect_addr;
    end else begin
      case (state_reg)
        FETCH: begin
          if (lat_cnt_reg == LAT_LAST) begin
            lat_cnt_next   = '0;
            fetch_ptr_next = fetch_ptr_reg + AW'(1);
            if (will_be_full) begin
              state_next = FULL;
            end
          end else begin
            lat_cnt_next = lat_cnt_reg + LW'(1);
          end
        end
        FULL: begin
          lat_cnt_next = '0;
          if (pop) begin
            state_next = FETCH;
          end
        end
        default: state_next = FETCH;
      endcase
    end
  end

  // Output logic
  always_comb begin
    push            = (state_reg == FETCH) && (lat_cnt_reg == LAT_LAST) &&
                      !bus.redirect && (!fifo_full || pop);
    pop             = !fifo_empty && bus.instr_ready && !bus.redirect;
    rom_rd_next     = (state_next == FETCH);
    bus.instr_valid = !fifo_empty;
    // Head is forced to zero while empty so the CPU never sees stale data.
    {bus.instr_addr, bus.instr_data} = fifo_empty ? '0 : fifo_rdata;
  end

  assign bus.rom_addr = fetch_ptr_reg;
  assign bus.rom_rd   = rom_rd_reg;

`ifdef FETCH_PERF_EN
  logic [15:0] stall_cycles_reg;
  logic [15:0] redirect_count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_reg   <= '0;
      redirect_count_reg <= '0;
    end else begin
      if (bus.instr_ready && fifo_empty && (stall_cycles_reg != 16'hFFFF)) begin
        stall_cycles_reg <= stall_cycles_reg + 16'd1;
      end
      if (bus.redirect && (redirect_count_reg != 16'hFFFF)) begin
        redirect_count_reg <= redirect_count_reg + 16'd1;
      end
    end
  end

  assign stall_cycles   = stall_cycles_reg;
  assign redirect_count = redirect_count_reg;
`endif

endmodule
